// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit-level blocks: bit-FSM states,
// default SCL timing and the phase-counter width helper.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } bit_state_t;

  localparam int unsigned LOW_CYCLES_DEF   = 4;
  localparam int unsigned HIGH_CYCLES_DEF  = 4;
  localparam int unsigned SAMPLE_CYCLE_DEF = 2;

  // Bits needed to hold a phase count of up to max(a, b).
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/i2c_sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs (SCL/SDA sensing),
// synchronous active-high reset to RESET_VAL.
module i2c_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/i2c_master_read_bit.sv
// Bit-level I2C master receiver: one SCL pulse per go, SDA sampled in the
// high phase, result on data with a one-cycle finish strobe.
module i2c_master_read_bit
  import i2c_pkg::*;
#(
  parameter int unsigned LOW_CYCLES   = LOW_CYCLES_DEF,
  parameter int unsigned HIGH_CYCLES  = HIGH_CYCLES_DEF,
  parameter int unsigned SAMPLE_CYCLE = SAMPLE_CYCLE_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic go,
  output logic finish,
  output logic data,
  output logic scl,
  input  logic sda
);

  localparam int unsigned CW = cnt_width(LOW_CYCLES, HIGH_CYCLES);
  localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_CYCLES);
  localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYCLES);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(SAMPLE_CYCLE);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  bit_state_t    r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_scl, w_scl_nx;
  logic          r_finish, w_finish_nx;
  logic          r_data, w_data_nx;
  logic          w_sda_s;

  i2c_sync_2ff #(.RESET_VAL(1'b1)) u_sda_sync (
    .i_clk (clock),
    .i_rst (reset),
    .i_d   (sda),
    .o_q   (w_sda_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_scl    <= 1'b1;
      r_finish <= 1'b0;
      r_data   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_scl    <= w_scl_nx;
      r_finish <= w_finish_nx;
      r_data   <= w_data_nx;
    end
  end

  // Next values are computed for the registered outputs, so scl/finish
  // change on the same edge as the state they belong to.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_scl_nx    = r_scl;
    w_finish_nx = 1'b0;
    w_data_nx   = r_data;
    unique case (r_state)
      IDLE: begin
        if (go) begin
          w_state_nx = LOW;
          w_cnt_nx   = CNT_ONE;
          w_scl_nx   = 1'b0;
        end
      end
      LOW: begin
        if (r_cnt == LOW_LAST) begin
          w_state_nx = HIGH;
          w_cnt_nx   = CNT_ONE;
          w_scl_nx   = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      HIGH: begin
        if (r_cnt == SAMPLE_AT) begin
          w_data_nx = w_sda_s;
        end
        if (r_cnt == HIGH_LAST) begin
          w_state_nx  = DONE;
          w_cnt_nx    = '0;
          w_scl_nx    = 1'b0;
          w_finish_nx = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_scl_nx = 1'b0;
        if (go) begin
          w_state_nx = LOW;
          w_cnt_nx   = CNT_ONE;
        end else begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign scl    = r_scl;
  assign finish = r_finish;
  assign data   = r_data;

endmodule

// File: tb/tb_i2c_master_read_bit.sv
// Directed bench for i2c_master_read_bit with default timing (4/4/2):
// per-cycle vector table plus hand-written multi-cycle corner sequences.
module tb_i2c_master_read_bit;

  logic clock = 1'b0;
  logic reset;
  logic go;
  logic sda;
  logic finish;
  logic data;
  logic scl;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic go;
    logic sda;
    logic scl;
    logic fin;
    logic dat;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  i2c_master_read_bit #(
    .LOW_CYCLES   (4),
    .HIGH_CYCLES  (4),
    .SAMPLE_CYCLE (2)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .go     (go),
    .finish (finish),
    .data   (data),
    .scl    (scl),
    .sda    (sda)
  );

  function automatic void add(input logic g, input logic s, input logic e_scl,
                              input logic e_fin, input logic e_dat);
    vec_t v;
    v.go = g; v.sda = s; v.scl = e_scl; v.fin = e_fin; v.dat = e_dat;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs are driven 1ns after an edge; outputs are checked 1ns after the next.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One bit: go for a single edge, optional sda change before edge tog_row,
  // then expect finish on the 9th edge with the given data.
  task automatic run_bit(input string name, input int tog_row, input logic tog_val,
                         input logic exp_dat);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    go   = 1'b1;
    for (int r = 0; r < 20 && !seen; r++) begin
      if (r == tog_row) sda = tog_val;
      tick();
      go = 1'b0;
      lat++;
      if (finish === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s.timeout: got no finish expected finish within 20 cycles", name);
    end
    chk_int({name, ".latency"}, lat, 9);
    chk({name, ".data"}, data, exp_dat);
    chk({name, ".scl_at_finish"}, scl, 1'b0);
    tick();
    chk({name, ".finish_single"}, finish, 1'b0);
    chk({name, ".scl_after"}, scl, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single bit, sda=1, go for one cycle only (later go=0 is ignored mid-bit).
    add(1,1,0,0,0);
    add(0,1,0,0,0); add(0,1,0,0,0); add(0,1,0,0,0);
    add(0,1,1,0,0); add(0,1,1,0,0); add(0,1,1,0,1); add(0,1,1,0,1);
    add(0,1,0,1,1);
    add(0,1,0,0,1); add(0,1,0,0,1);
    // Idle with scl parked low, sda moves to 0 and settles.
    add(0,0,0,0,1); add(0,0,0,0,1);
    // go held: bit 1 reads 0, sda goes 1 while scl low, bit 2 reads 1.
    add(1,0,0,0,1); add(1,0,0,0,1); add(1,0,0,0,1); add(1,0,0,0,1);
    add(1,0,1,0,1); add(1,0,1,0,1); add(1,0,1,0,0); add(1,0,1,0,0);
    add(1,0,0,1,0);
    add(1,1,0,0,0); add(1,1,0,0,0); add(1,1,0,0,0); add(1,1,0,0,0);
    add(1,1,1,0,0); add(1,1,1,0,0); add(1,1,1,0,1); add(1,1,1,0,1);
    add(1,1,0,1,1);
    add(0,1,0,0,1); add(0,1,0,0,1);

    reset = 1'b1;
    go    = 1'b0;
    sda   = 1'b1;
    tick();
    tick();
    chk("reset.scl", scl, 1'b1);
    chk("reset.finish", finish, 1'b0);
    chk("reset.data", data, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle[%0d].scl", i), scl, 1'b1);
      chk($sformatf("idle[%0d].finish", i), finish, 1'b0);
      chk($sformatf("idle[%0d].data", i), data, 1'b0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      go  = vecs[i].go;
      sda = vecs[i].sda;
      tick();
      chk($sformatf("vec[%0d].scl", i), scl, vecs[i].scl);
      chk($sformatf("vec[%0d].finish", i), finish, vecs[i].fin);
      chk($sformatf("vec[%0d].data", i), data, vecs[i].dat);
    end
    go = 1'b0;

    // sda rises in high-phase cycle 4, after the sample edge: data stays 0.
    sda = 1'b0;
    tick();
    tick();
    run_bit("late_toggle", 8, 1'b1, 1'b0);

    // sda rises in the sample cycle itself: too late for the synchronizer.
    sda = 1'b0;
    tick();
    tick();
    run_bit("sample_edge_toggle", 6, 1'b1, 1'b0);

    // Fresh bit reading 1, then reset in the high phase of the next bit.
    tick();
    tick();
    run_bit("pre_reset_bit", -1, 1'b1, 1'b1);
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_high.scl", scl, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset.scl", scl, 1'b1);
    chk("mid_reset.finish", finish, 1'b0);
    chk("mid_reset.data", data, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("post_reset[%0d].scl", i), scl, 1'b1);
      chk($sformatf("post_reset[%0d].finish", i), finish, 1'b0);
    end
    run_bit("after_reset", -1, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
